// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB-first on dout,
// repeated reps+1 times back-to-back, with done/err status pulses.
module seq_pattern_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       len,
    input  logic [3:0]       reps,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] WMAX = 5'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] pat_q;
    logic [3:0]       len_q;
    logic [3:0]       idx;
    logic [3:0]       rep_cnt;
    logic             len_ok;
    logic [15:0]      pat_ext;

    assign len_ok  = (len != 4'd0) && ({1'b0, len} <= WMAX);
    // Zero-extended so the 4-bit index always selects a real bit.
    assign pat_ext = 16'(pat_q);

    // Handshake: start is a level sampled only in IDLE/DONE; there is no
    // back-pressure on dout -- a bit is present exactly when dout_valid=1.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx     <= '0;
            rep_cnt <= '0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (len_ok) begin
                            pat_q   <= pattern;
                            len_q   <= len;
                            idx     <= len - 4'd1;
                            rep_cnt <= reps;
                            state   <= SEND;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (idx != 4'd0) begin
                        idx <= idx - 4'd1;
                    end else if (rep_cnt != 4'd0) begin
                        rep_cnt <= rep_cnt - 4'd1;
                        idx     <= len_q - 4'd1;
                    end else begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dout_valid = (state == SEND);
    assign busy       = (state == SEND);
    assign done       = (state == DONE);
    assign dout       = (state == SEND) && pat_ext[idx];
    assign dbg_state  = state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: expected bits are queued at start time
// and popped against dout each valid cycle; a 1101 detector model counts hits.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] dbg_state;

    logic [0:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         hits  = 0;

    seq_pattern_gen #(.WIDTH(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .reps       (reps),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
        chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Drives a one-cycle start and queues the bits the stream must carry.
    task automatic start_xfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        pattern = p;
        len     = l;
        reps    = r;
        start   = 1'b1;
        hits    = 0;
        for (int k = 0; k <= int'(r); k++)
            for (int b = int'(l) - 1; b >= 0; b--)
                exp_q.push_back(p[b]);
        tick();
        start = 1'b0;
    endtask

    // Checks every queued bit, optionally pokes inputs at step poke, and
    // stops in the DONE cycle without advancing past it.
    task automatic drain(input int poke);
        logic [3:0] sh = 4'd0;
        logic [0:0] eb;
        int         nv = 0;
        int         k  = 0;
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            chk("valid", 32'(dout_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            chk("err_send", 32'(err), 32'd0);
            chk("dout", 32'(dout), 32'(eb));
            sh = {sh[2:0], dout};
            nv++;
            if (nv >= 4 && sh == 4'b1101) hits++;
            if (k == poke) begin
                start   = 1'b1;
                pattern = 8'hFF;
                len     = 4'd2;
                reps    = 4'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("valid_in_done", 32'(dout_valid), 32'd0);
        chk("dout_in_done", 32'(dout), 32'd0);
    endtask

    initial begin
        logic [0:0] eb;
        clr = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0;
        tick();
        tick();
        clr = 1'b0;
        chk_idle("reset");

        // Single 1101 pattern
        start_xfer(8'h0D, 4'd4, 4'd0);
        drain(-1);
        tick();
        chk_idle("after_single");

        // Three repetitions feeding a 1101 detector
        start_xfer(8'h0D, 4'd4, 4'd2);
        drain(-1);
        chk("detector_hits", 32'(hits), 32'd3);
        tick();

        // Rejected starts: len=0 and len>WIDTH
        pattern = 8'hFF; len = 4'd0; reps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_len0", 32'(err), 32'd1);
        chk("busy_len0", 32'(busy), 32'd0);
        chk("valid_len0", 32'(dout_valid), 32'd0);
        chk("done_len0", 32'(done), 32'd0);
        tick();
        chk_idle("after_len0");
        len = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_len9", 32'(err), 32'd1);
        chk("busy_len9", 32'(busy), 32'd0);
        chk("valid_len9", 32'(dout_valid), 32'd0);
        chk("done_len9", 32'(done), 32'd0);
        tick();
        chk_idle("after_len9");

        // Reset after the second bit aborts the stream
        start_xfer(8'h0D, 4'd4, 4'd0);
        eb = exp_q.pop_front();
        chk("abort_bit1", 32'(dout), 32'(eb));
        tick();
        eb = exp_q.pop_front();
        chk("abort_bit2", 32'(dout), 32'(eb));
        chk("abort_valid2", 32'(dout_valid), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
        chk_idle("abort_cycle1");
        tick();
        chk_idle("abort_cycle2");
        tick();
        chk_idle("abort_cycle3");
        start_xfer(8'h0D, 4'd4, 4'd0);
        drain(-1);
        tick();

        // Start and input changes during SEND are ignored
        start_xfer(8'h0D, 4'd4, 4'd1);
        drain(2);
        tick();
        chk_idle("after_poke");

        // Back-to-back: new start sampled at the edge ending DONE
        start_xfer(8'h0D, 4'd4, 4'd0);
        drain(-1);
        start_xfer(8'hA5, 4'd8, 4'd0);
        drain(-1);
        tick();

        // len=1 with maximum repeats; upper pattern bits ignored
        start_xfer(8'h55, 4'd1, 4'd15);
        drain(-1);
        tick();
        start_xfer(8'hFE, 4'd1, 4'd2);
        drain(-1);
        tick();

        // clr and start on the same edge: reset wins
        pattern = 8'h0D; len = 4'd4; reps = 4'd0; start = 1'b1; clr = 1'b1;
        tick();
        start = 1'b0; clr = 1'b0;
        chk_idle("clr_vs_start");
        tick();
        chk_idle("clr_vs_start_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern generator that drives a programmable bit pattern, MSB-first, onto a one-bit stream, optionally repeated back-to-back. It is the transmit-side companion of the lab's serial sequence detectors: its `dout` feeds a detector's `din` on the same clock. Benches and board demos use it to produce detector stimulus, such as repeated `1101` streams, without hand-written per-cycle stimulus.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits. Legal range 1..15.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `clr`  in  1  reset, synchronous, active-high. It overrides every other input.
- `start`  in  1  transfer request. Sampled only in IDLE or DONE.
- `pattern`  in  WIDTH  bits to send. Sent from bit `len-1` down to bit 0. Bits above `len-1` are ignored.
- `len`  in  4  pattern length. Legal range 1..WIDTH.
- `reps`  in  4  repeat count. The pattern is sent `reps+1` times (1..16).
- `dout`  out  1  serial data. 0 whenever `dout_valid`=0.
- `dout_valid`  out  1  high while `dout` carries a pattern bit.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse after the last bit.
- `err`  out  1  one-cycle pulse when a start is rejected.

## Operation
- **States**
  - IDLE: all outputs 0.
  - SEND: `busy`=1, `dout_valid`=1, `dout`=`pat_q[idx]`.
  - DONE: `done`=1; all other outputs 0.
- **Internal registers**
  - `pat_q` (WIDTH bits)
  - `len_q` (4 bits)
  - `idx` (4 bits, current bit index)
  - `rep_cnt` (4 bits, repeats remaining)
- **Start in IDLE or DONE with legal `len`**
  - Load `pat_q`←`pattern`, `len_q`←`len`, `idx`←`len-1`, `rep_cnt`←`reps`.
  - Go to SEND.
- **Start in IDLE or DONE with illegal `len`** (`len`=0 or `len`>WIDTH)
  - Go to IDLE. Pulse `err`. Internal registers are not loaded.
- **No start in DONE:** go to IDLE.
- **SEND, per cycle**
  - `idx`>0: `idx`←`idx-1`.
  - `idx`=0 and `rep_cnt`>0: `rep_cnt`←`rep_cnt-1`, `idx`←`len_q-1`. The next repetition follows with no gap cycle.
  - `idx`=0 and `rep_cnt`=0: go to DONE.
- **Ignored inputs**
  - `start` during SEND is ignored. No `err`, and the stream is unaffected.
  - Changes on `pattern`, `len` and `reps` during SEND have no effect; the latched copies are used.
- **Outputs are Moore.**
  - `dout`, `dout_valid`, `busy` and `done` are decoded from the state and index registers only, with no combinational input-to-output path.
  - `err` is a registered flag.
- **Reset (`clr`=1 at an edge)**
  - State←IDLE; all internal registers←0; `err`←0.
  - Mid-transfer reset aborts the stream: no `done` pulse, and remaining bits are discarded.
  - `clr` and `start` at the same edge: reset wins and the start is lost.

## Timing
- Edge E0 samples a legal `start`.
  - First bit, `pattern[len-1]`, is valid in the cycle after E0.
  - Exactly `len*(reps+1)` consecutive `dout_valid` cycles follow.
  - `done` is high in the single cycle after the last bit.
- Back-to-back transfers:
  - A `start` sampled at the edge that ends DONE begins the new stream in the next cycle.
  - Minimum gap between two streams is therefore one cycle, the DONE cycle.
- Rejected start at E0: `err`=1 for the cycle after E0; `busy` stays 0.
- Reset values of all outputs are 0. The first cycle after the `clr` edge is IDLE.
- `len`=1 is legal. Each repetition is one cycle, and `idx` stays 0 while `rep_cnt` decrements.

## Test plan
- **Single pattern.** `pattern`=8'h0D, `len`=4, `reps`=0, one-cycle `start` → `dout` = 1,1,0,1 with `dout_valid`=1 in cycles 1–4, `done` in cycle 5, `busy` 0 in cycle 5.
- **Repeats into detector.** `pattern`=8'h0D, `len`=4, `reps`=2, with `dout`→detector `din` on the shared `clk` → 12 valid bits 110111011101, then `done`. Detector asserts `dout` exactly 3 times.
- **Rejected starts.** `start` with `len`=0, then with `len`=9 (WIDTH=8) → `err` pulses one cycle each; `busy`, `dout_valid` and `done` stay 0.
- **Mid-stream reset.** `clr`=1 for one edge after the 2nd bit of a 4-bit transfer → next cycle all outputs 0, no `done` pulse. A subsequent `start` produces the full, correct pattern.
- **Start during SEND.** `start` asserted during SEND → ignored; the stream and `done` timing are unchanged.
- **Back-to-back transfer.** `start` during the DONE cycle with `pattern`=8'hA5, `len`=8 → 10100101 begins in the cycle after DONE.
- **Boundary case.** `len`=1, `reps`=15 → 16 valid cycles of `pattern[0]`, then `done`.
